// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the four-requester memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam int NUM_REQ = 4;

  localparam logic [1:0] REQ_IFETCH   = 2'd0;
  localparam logic [1:0] REQ_LSU      = 2'd1;
  localparam logic [1:0] REQ_UNCACHED = 2'd2;
  localparam logic [1:0] REQ_DEBUG    = 2'd3;

  function automatic logic [NUM_REQ-1:0] idx2oh(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and shared-port signals of the arbiter; slave is the arbiter view.
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       req;
  logic [WIDTH-1:0] addr0;
  logic [WIDTH-1:0] addr1;
  logic [WIDTH-1:0] addr2;
  logic [WIDTH-1:0] addr3;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             bus_valid;
  logic [WIDTH-1:0] bus_addr;
  logic             bus_ready;
  logic             bus_done;
  logic [3:0]       done;
  logic             timeout_err;

  modport slave (
    input  req, addr0, addr1, addr2, addr3, bus_ready, bus_done,
    output gnt, sel, bus_valid, bus_addr, done, timeout_err
  );

  modport master (
    output req, addr0, addr1, addr2, addr3, bus_ready, bus_done,
    input  gnt, sel, bus_valid, bus_addr, done, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick4.sv
// Combinational round-robin pick: first set request after 'last', wrapping.
module rr_pick4
  import mem_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic               found,
  output logic [1:0]         idx
);

  logic [1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    cand  = 2'd0;
    // k = NUM_REQ wraps back to 'last' itself, which is lowest priority
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory request port among four requesters; grant held per transaction.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [1:0]           sel_q, sel_d;
  logic [1:0]           last_q, last_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 pick_found;
  logic [1:0]           pick_idx;
  logic [NUM_REQ-1:0]   done_c;
  logic                 timeout_c;
  logic [WIDTH-1:0]     addr_sel;

  rr_pick4 u_pick (
    .req   (bus.req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= REQ_IFETCH;
      last_q  <= REQ_DEBUG;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    done_c    = '0;
    timeout_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_found) begin
          state_d = ST_ISSUE;
          sel_d   = pick_idx;
          gnt_d   = idx2oh(pick_idx);
          last_d  = pick_idx;
        end
      end
      ST_ISSUE: begin
        if (bus.bus_ready) begin
          if (bus.bus_done) begin
            done_c  = gnt_q;
            state_d = ST_IDLE;
            gnt_d   = '0;
            sel_d   = REQ_IFETCH;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        // a completion in the final counted cycle still wins over the abort
        if (bus.bus_done) begin
          done_c  = gnt_q;
          state_d = ST_IDLE;
          gnt_d   = '0;
          sel_d   = REQ_IFETCH;
        end else if (cnt_q == TO_CNT) begin
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
          gnt_d     = '0;
          sel_d     = REQ_IFETCH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        sel_d   = REQ_IFETCH;
      end
    endcase
  end

  always_comb begin
    unique case (sel_q)
      2'd0:    addr_sel = bus.addr0;
      2'd1:    addr_sel = bus.addr1;
      2'd2:    addr_sel = bus.addr2;
      default: addr_sel = bus.addr3;
    endcase
  end

  assign bus.gnt         = gnt_q;
  assign bus.sel         = sel_q;
  assign bus.bus_valid   = (state_q == ST_ISSUE);
  assign bus.bus_addr    = addr_sel;
  assign bus.done        = done_c;
  assign bus.timeout_err = timeout_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: driver pushes expected grants/outcomes, monitor pops on done/timeout.
module tb_mem_port_arbiter;

  localparam int W  = 32;
  localparam int TO = 4;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    bit          to;
    int          stall;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_m  = 3;
  exp_t q[$];
  logic [31:0] a[4];

  mem_port_arbiter_if #(.WIDTH(W)) bus ();

  mem_port_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.addr0 = a[0];
  assign bus.addr1 = a[1];
  assign bus.addr2 = a[2];
  assign bus.addr3 = a[3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: scan requesters last+1, last+2, ... mod 4.
  function automatic int model_pick(input logic [3:0] pat, input int last);
    for (int k = 1; k <= 4; k++)
      if (pat[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.req       = 4'b0000;
      bus.bus_ready = 1'($urandom_range(0, 1));
      bus.bus_done  = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  // dly = 0: done with ready; dly = k: done in k-th WAIT cycle; dly > TO+1: abort.
  task automatic run_txn(input logic [3:0] pat, input int stall, input int dly,
                         input bit drop, input bit rnd_addr);
    exp_t e;
    int   nwait;
    if (rnd_addr) for (int i = 0; i < 4; i++) a[i] = $urandom;
    bus.req       = pat;
    bus.bus_ready = 1'($urandom_range(0, 1));
    bus.bus_done  = 1'($urandom_range(0, 1));
    e.idx   = model_pick(pat, last_m);
    e.addr  = a[e.idx];
    e.to    = (dly > TO + 1);
    e.stall = stall;
    e.cyc   = cyc;
    last_m  = e.idx;
    q.push_back(e);
    step();
    for (int i = 0; i < stall; i++) begin
      bus.bus_ready = 1'b0;
      bus.bus_done  = 1'($urandom_range(0, 1));
      if (drop) bus.req = 4'($urandom);
      step();
    end
    bus.bus_ready = 1'b1;
    bus.bus_done  = (dly == 0);
    step();
    nwait = e.to ? TO + 1 : dly;
    for (int k = 1; k <= nwait; k++) begin
      bus.bus_ready = 1'($urandom_range(0, 1));
      bus.bus_done  = (!e.to && k == dly);
      if (drop) bus.req = 4'($urandom);
      step();
    end
    bus.bus_ready = 1'b0;
    bus.bus_done  = 1'b0;
    bus.req       = 4'b0000;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_gnt"},   64'(bus.gnt), 64'd0);
    chk({nm, "_sel"},   64'(bus.sel), 64'd0);
    chk({nm, "_valid"}, 64'(bus.bus_valid), 64'd0);
    chk({nm, "_done"},  64'(bus.done), 64'd0);
    chk({nm, "_toerr"}, 64'(bus.timeout_err), 64'd0);
  endtask

  // Monitor
  logic [3:0] prev_gnt = '0;
  int         vcnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_gnt = '0;
      vcnt     = 0;
    end else begin
      if (bus.gnt != 0 && prev_gnt == 0) begin
        vcnt = 0;
        if (q.size() == 0) chk("grant_unexpected", 64'(bus.gnt), 64'd0);
        else chk("grant_latency", 64'(cyc), 64'(q[0].cyc + 1));
      end
      if (bus.bus_valid) vcnt++;
      if (bus.gnt == 0) chk("valid_without_grant", 64'(bus.bus_valid), 64'd0);
      else if (q.size() != 0) begin
        chk("gnt", 64'(bus.gnt), 64'(4'b0001 << q[0].idx));
        chk("sel", 64'(bus.sel), 64'(q[0].idx));
        chk("bus_addr", 64'(bus.bus_addr), 64'(q[0].addr));
      end
      if (bus.done != 0 || bus.timeout_err) begin
        if (q.size() == 0) begin
          chk("done_unexpected", 64'(bus.done), 64'd0);
          chk("toerr_unexpected", 64'(bus.timeout_err), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done", 64'(bus.done), e.to ? 64'd0 : 64'(4'b0001 << e.idx));
          chk("timeout_err", 64'(bus.timeout_err), 64'(e.to));
          chk("valid_cycles", 64'(vcnt), 64'(e.stall + 1));
        end
      end
      prev_gnt = bus.gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) a[i] = 32'h0;
    bus.req       = 4'b0000;
    bus.bus_ready = 1'b0;
    bus.bus_done  = 1'b0;
    #2;
    chk_zero("in_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_zero("idle");
    end

    // single requester, immediate completion
    a[0] = 32'h0000_1000;
    run_txn(4'b0001, 0, 0, 1'b0, 1'b0);
    idle_cycles(1);
    // all requesting, back-to-back
    for (int i = 0; i < 5; i++) run_txn(4'b1111, 0, 0, 1'b0, 1'b1);
    idle_cycles(2);
    // set last=1, then 1001 picks 3, then wraps to 0
    run_txn(4'b0010, 0, 0, 1'b0, 1'b1);
    run_txn(4'b1001, 0, 0, 1'b0, 1'b1);
    run_txn(4'b1001, 0, 0, 1'b0, 1'b1);
    // requester 2: 3 stall cycles, done 5 WAIT cycles later, req dropping
    idle_cycles(1);
    run_txn(4'b0100, 3, 5, 1'b1, 1'b1);
    // abort
    run_txn(4'b1010, 1, TO + 4, 1'b0, 1'b1);
    idle_cycles(2);

    for (int t = 0; t < 150; t++) begin
      int dly;
      dly = ($urandom_range(0, 5) == 0) ? int'($urandom_range(TO, TO + 4))
                                        : int'($urandom_range(0, 3));
      run_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), dly,
              1'($urandom_range(0, 1)), 1'b1);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    // reset while in WAIT
    for (int i = 0; i < 4; i++) a[i] = $urandom;
    bus.req = 4'b0100;
    begin
      exp_t e;
      e.idx = model_pick(4'b0100, last_m); e.addr = a[e.idx];
      e.to = 1'b0; e.stall = 0; e.cyc = cyc;
      q.push_back(e);
    end
    step();
    bus.bus_ready = 1'b1;
    bus.bus_done  = 1'b0;
    step();
    bus.bus_ready = 1'b0;
    step();
    #2;
    rst = 1'b1;
    q.delete();
    last_m = 3;
    #1;
    chk_zero("rst_in_wait");
    step();
    chk_zero("rst_held");
    rst = 1'b0;
    bus.req = 4'b0000;
    idle_cycles(1);
    run_txn(4'b1111, 0, 0, 1'b0, 1'b1);
    idle_cycles(3);

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
